lenet_pool_chan_sched: RTL and testbench
========================================

// Module: lenet_pool_chan_sched
// PURPOSE
//   Sequences one shared LeNet pooling stage across CH feature-map channels, one channel at a time.
//   Pulls pixels from an upstream source through a valid/ready handshake.
//   Generates the vsync, hsync and valid framing the pooling stage consumes, then counts the pooled results.
//   Sits between the conv-layer output buffer and the pooling instance; reports busy/done to the layer controller.
// PARAMETERS
//   WD        1   pixel data width
//   SIZE      12  input map edge in pixels; must be even, at most 255
//   CH        6   channels per layer
//   VS_CYC    2   o_vsync pulse length per channel, in cycles; must be at least 1 (clears the pooling FIFO)
//   GAP       4   idle cycles between rows; must be at least 1
//   DRAIN_MAX 64  maximum cycles spent waiting for pooled outputs after the last row
// PORTS
//   i_sclk        in   1          clock
//   i_rstn        in   1          synchronous reset, active-low
//   i_start       in   1          start-of-layer request; sampled only in IDLE
//   i_src_valid   in   1          source pixel valid
//   i_src_data    in   WD         source pixel
//   o_src_ready   out  1          scheduler accepts a pixel this cycle
//   o_vsync       out  1          frame/channel start pulse to the pooling stage
//   o_hsync       out  1          row-active level to the pooling stage
//   o_valid       out  1          pixel valid to the pooling stage
//   o_tdata       out  WD         pixel to the pooling stage
//   o_chan        out  CHW        current channel index, where CHW = $clog2(CH)
//   i_pool_valid  in   1          valid strobe from the pooling stage output
//   o_busy        out  1          high from leaving IDLE until return to IDLE
//   o_done        out  1          1-cycle pulse after the last channel has drained
//   o_err         out  1          sticky pooled-count error (macro only)
// BEHAVIOUR
//   Reset (i_rstn=0 at a clock edge): state IDLE; counters cleared; o_chan = 0; every output = 0.
//   Reset mid-operation: the layer is aborted immediately; no o_done is produced.
//   FSM states: IDLE, VSYNC, LINE, GAP, DRAIN.
//     IDLE  -> VSYNC  on i_start.
//     VSYNC -> LINE   after VS_CYC cycles; o_vsync is high for exactly VS_CYC cycles.
//     LINE  -> GAP    after SIZE accepted pixels, when rows remain.
//     LINE  -> DRAIN  after the SIZE-th accepted pixel of row SIZE.
//     GAP   -> LINE   after GAP cycles.
//     DRAIN -> VSYNC  on drain exit with o_chan < CH-1; o_chan increments.
//     DRAIN -> IDLE   on drain exit with o_chan = CH-1; o_done pulses, o_chan returns to 0.
//   Handshake:
//     o_src_ready = 1 only in LINE. A pixel is accepted when i_src_valid & o_src_ready.
//     A source stall mid-row holds LINE: o_hsync stays 1 and o_valid stays 0.
//   Pipeline: o_valid, o_tdata and o_hsync are registered, with 1-cycle latency from acceptance/state.
//     o_hsync = registered (state==LINE), so its rise coincides with the cycle o_valid can first rise.
//     o_tdata holds its value when o_valid = 0.
//   Pooled-output counter:
//     Counts i_pool_valid per channel; cleared during VSYNC. Expected count = (SIZE/2)^2.
//     i_pool_valid is counted in any state except IDLE.
//     If a pooled strobe coincides with the drain exit, it is counted before the comparison.
//   Column counter: wraps SIZE-1 -> 0. Row counter: increments on that wrap.
//   i_start while o_busy = 1: ignored.
//   o_busy = 0 only in IDLE, including the cycle o_done pulses.
// CONFIGURATION
//   POOL_SCHED_CNTCHK_EN defined:
//     DRAIN exits when the pooled count reaches (SIZE/2)^2, or after DRAIN_MAX cycles, whichever comes first.
//     A timeout, or a count above the expected value at any time, sets o_err.
//     o_err is cleared only by reset or by i_start accepted in IDLE.
//   POOL_SCHED_CNTCHK_EN undefined:
//     DRAIN always lasts exactly DRAIN_MAX cycles; o_err is tied to 0; the counter logic is omitted.
// STRUCTURE
//   Package lenet_pool_pkg: state enum (IDLE/VSYNC/LINE/GAP/DRAIN); function returning the expected pooled count;
//     width constants derived with $clog2 for column, row, gap and drain counters.
//   One sub-module, pool_out_checker: counts i_pool_valid, compares against the expected count,
//     and provides the drain-complete and error flags. It is instantiated only under POOL_SCHED_CNTCHK_EN.
// TESTING
//   SIZE=4, CH=2, src always valid, pool model returns 4 strobes/ch -> VSYNC, 4 rows of 4 valids with 4-cycle gaps, o_done once, o_err=0.
//   Source drops i_src_valid for 3 cycles at pixel 2 of row 1 -> o_hsync held 1, exactly 16 valids per ch, data order preserved.
//   Pool model returns only 3 strobes (macro on) -> DRAIN exits after 64 cycles, o_err=1, next channel still runs.
//   Pool model returns 5 strobes (macro on) -> o_err sets on the 5th strobe; o_err clears on the next i_start.
//   i_rstn=0 during row 2 of ch 1 -> next cycle all outputs 0, o_chan=0, IDLE; no o_done pulse.
//   i_start pulsed while busy; i_start coincident with o_done -> ignored; a new layer starts only from IDLE one cycle later.

Source files
------------

// File: rtl/lenet_pool_pkg.sv
// lenet_pool_pkg: shared types and sizing helpers for the pooling channel scheduler.
package lenet_pool_pkg;

  // Scheduler states, in the order a channel walks through them
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_VSYNC = 3'd1,
    ST_LINE  = 3'd2,
    ST_GAP   = 3'd3,
    ST_DRAIN = 3'd4
  } pool_state_e;

  // Largest supported map edge; column and row counters are sized for it
  localparam int SIZE_MAX = 255;
  localparam int COL_W    = $clog2(SIZE_MAX);
  localparam int ROW_W    = $clog2(SIZE_MAX);

  // Bits needed for a counter that runs 0 .. n-1 (gap, drain, vsync timers)
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Pooled outputs expected per channel for 2x2 pooling of a size x size map
  function automatic int exp_pool_count(input int size);
    return (size / 2) * (size / 2);
  endfunction

endpackage

// File: rtl/pool_out_checker.sv
// pool_out_checker: counts pooled-output strobes for the current channel and
// flags drain completion and count errors (too many strobes, or drain timeout).
module pool_out_checker
  import lenet_pool_pkg::*;
#(
  parameter int EXP = 36
) (
  input  logic i_sclk,
  input  logic i_rstn,
  input  logic i_en,         // count strobes (scheduler not idle)
  input  logic i_clr,        // restart the count for a new channel
  input  logic i_strobe,     // pooled-output valid
  input  logic i_timeout,    // drain budget expired without reaching EXP
  input  logic i_err_clr,    // new layer accepted
  output logic o_drain_done, // count (including this cycle's strobe) reached EXP
  output logic o_err
);

  // Counter saturates at EXP+1 so "above expected" stays visible without wrapping
  localparam int CW = cnt_w(EXP + 2);
  localparam logic [CW-1:0] EXP_C = CW'(EXP);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_err;

  // Next count: a strobe in this cycle is included before any comparison
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_en && i_strobe && (r_cnt <= EXP_C)) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  assign o_drain_done = (w_cnt_nxt >= EXP_C);
  assign o_err        = r_err;

  // Per-channel strobe counter
  always_ff @(posedge i_sclk) begin
    if (!i_rstn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  // Sticky error: set on overflow or drain timeout, cleared by a new layer
  always_ff @(posedge i_sclk) begin
    if (!i_rstn) begin
      r_err <= 1'b0;
    end else if (i_err_clr) begin
      r_err <= 1'b0;
    end else if (i_timeout || (!i_clr && (w_cnt_nxt > EXP_C))) begin
      r_err <= 1'b1;
    end
  end

endmodule

// File: rtl/lenet_pool_chan_sched.sv
// lenet_pool_chan_sched: drives one shared LeNet pooling stage across CH channels,
// one at a time: vsync pulse, SIZE rows of SIZE pixels separated by idle gaps,
// then a drain window waiting for the pooled results.
// Optional feature macro: POOL_SCHED_CNTCHK_EN -- when defined, the drain ends as
// soon as all pooled outputs have arrived (or on timeout) and o_err reports count
// errors; otherwise the drain is a fixed DRAIN_MAX cycles and o_err is 0.
//
// Source handshake: a pixel moves when i_src_valid & o_src_ready are both high at
// a rising edge; o_src_ready is high in every LINE cycle and never elsewhere, and
// the source may drop i_src_valid at any time (the row simply stretches).
module lenet_pool_chan_sched
  import lenet_pool_pkg::*;
#(
  parameter  int WD        = 1,
  parameter  int SIZE      = 12,
  parameter  int CH        = 6,
  parameter  int VS_CYC    = 2,
  parameter  int GAP       = 4,
  parameter  int DRAIN_MAX = 64,
  localparam int CHW       = $clog2(CH)
) (
  input  logic           i_sclk,
  input  logic           i_rstn,
  input  logic           i_start,
  input  logic           i_src_valid,
  input  logic [WD-1:0]  i_src_data,
  output logic           o_src_ready,
  output logic           o_vsync,
  output logic           o_hsync,
  output logic           o_valid,
  output logic [WD-1:0]  o_tdata,
  output logic [CHW-1:0] o_chan,
  input  logic           i_pool_valid,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_err
);

  // One timer serves the vsync, gap and drain phases; size it for the longest
  localparam int TMR_MAX = (DRAIN_MAX > GAP) ? ((DRAIN_MAX > VS_CYC) ? DRAIN_MAX : VS_CYC)
                                             : ((GAP > VS_CYC) ? GAP : VS_CYC);
  localparam int TMR_W   = cnt_w(TMR_MAX);
  localparam logic [TMR_W-1:0] VS_LAST   = TMR_W'(VS_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP - 1);
  localparam logic [TMR_W-1:0] DRN_LAST  = TMR_W'(DRAIN_MAX - 1);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(SIZE - 1);
  localparam logic [CHW-1:0]   CHAN_LAST = CHW'(CH - 1);
  localparam int               EXP_POOL  = exp_pool_count(SIZE);

  pool_state_e      r_state;
  logic [TMR_W-1:0] r_tmr;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [CHW-1:0]   r_chan;
  logic             r_vsync;
  logic             r_done;
  logic             r_hsync;
  logic             r_valid;
  logic [WD-1:0]    r_tdata;

  logic w_acc;
  logic w_start_acc;
  logic w_drain_last;
  logic w_drain_exit;

  assign o_src_ready  = (r_state == ST_LINE);
  assign w_acc        = i_src_valid && o_src_ready;
  // A start arriving alongside o_done is dropped; the layer controller retries next cycle
  assign w_start_acc  = (r_state == ST_IDLE) && i_start && !r_done;
  assign w_drain_last = (r_tmr == DRN_LAST);

`ifdef POOL_SCHED_CNTCHK_EN
  logic w_drain_done;
  logic w_chk_err;

  pool_out_checker #(
    .EXP (EXP_POOL)
  ) u_chk (
    .i_sclk       (i_sclk),
    .i_rstn       (i_rstn),
    .i_en         (r_state != ST_IDLE),
    .i_clr        (r_state == ST_VSYNC),
    .i_strobe     (i_pool_valid),
    .i_timeout    ((r_state == ST_DRAIN) && w_drain_last && !w_drain_done),
    .i_err_clr    (w_start_acc),
    .o_drain_done (w_drain_done),
    .o_err        (w_chk_err)
  );

  assign w_drain_exit = (r_state == ST_DRAIN) && (w_drain_done || w_drain_last);
  assign o_err        = w_chk_err;
`else
  logic w_unused_pool;
  assign w_unused_pool = i_pool_valid;
  assign w_drain_exit  = (r_state == ST_DRAIN) && w_drain_last;
  assign o_err         = 1'b0;
`endif

  assign o_vsync = r_vsync;
  assign o_hsync = r_hsync;
  assign o_valid = r_valid;
  assign o_tdata = r_tdata;
  assign o_chan  = r_chan;
  assign o_busy  = (r_state != ST_IDLE);
  assign o_done  = r_done;

  // Channel sequencer: state, phase timer, pixel position, channel index, vsync/done
  always_ff @(posedge i_sclk) begin
    if (!i_rstn) begin
      r_state <= ST_IDLE;
      r_tmr   <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_chan  <= '0;
      r_vsync <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_acc) begin
            r_state <= ST_VSYNC;
            r_vsync <= 1'b1;
            r_tmr   <= '0;
            r_col   <= '0;
            r_row   <= '0;
          end
        end
        ST_VSYNC: begin
          if (r_tmr == VS_LAST) begin
            r_state <= ST_LINE;
            r_vsync <= 1'b0;
            r_tmr   <= '0;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        ST_LINE: begin
          if (w_acc) begin
            if (r_col == COL_LAST) begin
              r_col <= '0;
              r_tmr <= '0;
              if (r_row == ROW_LAST) begin
                r_row   <= '0;
                r_state <= ST_DRAIN;
              end else begin
                r_row   <= r_row + 1'b1;
                r_state <= ST_GAP;
              end
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (r_tmr == GAP_LAST) begin
            r_state <= ST_LINE;
            r_tmr   <= '0;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (w_drain_exit) begin
            r_tmr <= '0;
            if (r_chan == CHAN_LAST) begin
              r_state <= ST_IDLE;
              r_chan  <= '0;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_VSYNC;
              r_vsync <= 1'b1;
              r_chan  <= r_chan + 1'b1;
            end
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Pooling-side framing: registered row-active level, pixel valid and held pixel data
  always_ff @(posedge i_sclk) begin
    if (!i_rstn) begin
      r_hsync <= 1'b0;
      r_valid <= 1'b0;
      r_tdata <= '0;
    end else begin
      r_hsync <= (r_state == ST_LINE);
      r_valid <= w_acc;
      if (w_acc) begin
        r_tdata <= i_src_data;
      end
    end
  end

endmodule

// File: tb/tb_lenet_pool_chan_sched.sv
// tb_lenet_pool_chan_sched: directed layer runs with random pixel data and a
// behavioural pooling-stage model, checking framing, ordering, drain and errors.
module tb_lenet_pool_chan_sched;

  localparam int WD        = 8;
  localparam int SIZE      = 4;
  localparam int CH        = 2;
  localparam int VS_CYC    = 2;
  localparam int GAP       = 4;
  localparam int DRAIN_MAX = 64;
  localparam int CHW       = $clog2(CH);
  localparam int NPIX      = SIZE * SIZE;
  localparam int EXP_POOL  = (SIZE / 2) * (SIZE / 2);

  // ---------------- clock / reset ----------------
  logic           i_sclk;
  logic           i_rstn;
  logic           i_start;
  logic           i_src_valid;
  logic [WD-1:0]  i_src_data;
  logic           o_src_ready;
  logic           o_vsync;
  logic           o_hsync;
  logic           o_valid;
  logic [WD-1:0]  o_tdata;
  logic [CHW-1:0] o_chan;
  logic           i_pool_valid;
  logic           o_busy;
  logic           o_done;
  logic           o_err;

  initial i_sclk = 1'b0;
  always #5 i_sclk = ~i_sclk;

  lenet_pool_chan_sched #(
    .WD(WD), .SIZE(SIZE), .CH(CH), .VS_CYC(VS_CYC), .GAP(GAP), .DRAIN_MAX(DRAIN_MAX)
  ) dut (
    .i_sclk       (i_sclk),
    .i_rstn       (i_rstn),
    .i_start      (i_start),
    .i_src_valid  (i_src_valid),
    .i_src_data   (i_src_data),
    .o_src_ready  (o_src_ready),
    .o_vsync      (o_vsync),
    .o_hsync      (o_hsync),
    .o_valid      (o_valid),
    .o_tdata      (o_tdata),
    .o_chan       (o_chan),
    .i_pool_valid (i_pool_valid),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [WD-1:0] exp_q[$];
  logic [WD-1:0] src_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: drain length from the last pixel's o_valid cycle to the next vsync/done.
  // With count checking, the final pooled strobe lands in the first drain cycle.
  function automatic int exp_drain(input int n);
`ifdef POOL_SCHED_CNTCHK_EN
    return (n >= EXP_POOL) ? 1 : DRAIN_MAX;
`else
    return DRAIN_MAX;
`endif
  endfunction

  function automatic bit exp_err(input int n);
`ifdef POOL_SCHED_CNTCHK_EN
    return (n != EXP_POOL);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chan_end(input int chn, input int vcnt, input int rows, input int drain, input int n);
    chk($sformatf("ch%0d_valids", chn), vcnt, NPIX);
    chk($sformatf("ch%0d_rows", chn), rows, SIZE);
    chk($sformatf("ch%0d_drain", chn), drain, exp_drain(n));
  endtask

  // ---------------- driver: one layer ----------------
  // n0/n1: pooled strobes returned for channel 0/1 (EXP_POOL nominal, fewer or one extra)
  task automatic run_layer(input bit stall, input int n0, input int n1,
                           input bit poke_busy, input bit start_at_done, input bit abort);
    int  nstr[CH];
    int  sent, stall_left, cyc, vcnt, chn, last_v, vs_run, hs_low, rows, done_cnt, post;
    int  idx, r, c, nb, n;
    bit  prev_vs, prev_hs, fin, err_exp;
    logic [WD-1:0] v;
    logic [WD-1:0] e;

    nstr[0] = n0; nstr[1] = n1;
    sent = 0; stall_left = 3; cyc = 0; vcnt = 0; chn = -1; last_v = 0;
    vs_run = 0; hs_low = 0; rows = 0; done_cnt = 0; post = 0;
    prev_vs = 0; prev_hs = 0; fin = 0;
    err_exp = exp_err(n0) | exp_err(n1);

    src_q.delete();
    exp_q.delete();
    for (int k = 0; k < CH * NPIX; k++) begin
      v = WD'($urandom);
      src_q.push_back(v);
      exp_q.push_back(v);
    end

    i_start = 1'b1;
    while (!(fin && post >= 4)) begin
      @(negedge i_sclk);
      cyc++;
      i_start      = 1'b0;
      i_pool_valid = 1'b0;
      if (cyc > 1500) begin
        chk("layer_budget", fin, 1);
        break;
      end

      if (cyc == 1) begin
        chk("start_busy", o_busy, 1);
        chk("start_vsync", o_vsync, 1);
        chk("start_err_clear", o_err, 0);
      end

      // channel framing
      if (o_vsync && !prev_vs) begin
        if (chn >= 0 && chn < CH) chan_end(chn, vcnt, rows, cyc - last_v, nstr[chn]);
        chn++;
        vcnt = 0;
        rows = 0;
        chk("vsync_chan", o_chan, chn);
      end
      if (o_vsync) vs_run++;
      else if (prev_vs) begin
        chk("vsync_len", vs_run, VS_CYC);
        vs_run = 0;
      end

      // row framing: hsync low run between rows equals the gap
      if (o_hsync && !prev_hs) begin
        if (rows > 0) chk("row_gap", hs_low, GAP);
        rows++;
        hs_low = 0;
      end
      if (!o_hsync) hs_low++;

      // pixel stream and pooling-stage model (strobe when a 2x2 block completes)
      if (o_valid) begin
        chk("valid_hsync", o_hsync, 1);
        chk("valid_chan", o_chan, chn);
        chk("stream_len", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = 'x;
        chk("pixel_data", o_tdata, e);
        idx = vcnt;
        vcnt++;
        if (vcnt == NPIX) last_v = cyc;
        r = idx / SIZE;
        c = idx % SIZE;
        n = (chn >= 0 && chn < CH) ? nstr[chn] : EXP_POOL;
        if ((r % 2 == 1) && (c % 2 == 1)) begin
          nb = (r / 2) * (SIZE / 2) + c / 2;
          if (nb < EXP_POOL - 1 || n >= EXP_POOL) i_pool_valid = 1'b1;
        end
        if (n > EXP_POOL && idx == 0) i_pool_valid = 1'b1;
      end

      // layer completion
      if (o_done) begin
        done_cnt++;
        if (!fin) begin
          if (chn >= 0 && chn < CH) chan_end(chn, vcnt, rows, cyc - last_v, nstr[chn]);
          chk("done_busy", o_busy, 0);
          chk("done_chan", o_chan, 0);
          chk("done_last_ch", chn, CH - 1);
          chk("done_err", o_err, err_exp);
          fin = 1;
          if (start_at_done) i_start = 1'b1;
        end
      end else if (fin) begin
        post++;
        if (post == 1) chk("idle_after_done", o_busy, 0);
      end

      prev_vs = o_vsync;
      prev_hs = o_hsync;

      if (abort && chn == 1 && vcnt == 9) break;

      // spurious start requests while busy must be ignored
      if (poke_busy && o_busy && $urandom_range(0, 9) == 0) i_start = 1'b1;

      // source: always valid except a 3-cycle drop at pixel 2 of row 1
      if (sent < CH * NPIX) begin
        if (stall && (sent % NPIX) == SIZE + 2 && stall_left > 0) begin
          i_src_valid = 1'b0;
          stall_left--;
        end else begin
          i_src_valid = 1'b1;
          i_src_data  = src_q[sent];
        end
      end else begin
        i_src_valid = 1'b0;
      end
      if (i_src_valid && o_src_ready) begin
        sent++;
        if (sent % NPIX == 0) stall_left = 3;
      end
    end

    i_start      = 1'b0;
    i_src_valid  = 1'b0;
    i_pool_valid = 1'b0;

    if (abort) begin
      i_rstn = 1'b0;
      @(negedge i_sclk);
      chk("abort_vsync", o_vsync, 0);
      chk("abort_hsync", o_hsync, 0);
      chk("abort_valid", o_valid, 0);
      chk("abort_tdata", o_tdata, 0);
      chk("abort_chan", o_chan, 0);
      chk("abort_busy", o_busy, 0);
      chk("abort_ready", o_src_ready, 0);
      chk("abort_done", o_done, 0);
      chk("abort_err", o_err, 0);
      i_rstn = 1'b1;
      done_cnt = 0;
      repeat (150) begin
        @(negedge i_sclk);
        if (o_done) done_cnt++;
      end
      chk("abort_no_done", done_cnt, 0);
      chk("abort_idle", o_busy, 0);
      exp_q.delete();
    end else begin
      chk("done_once", done_cnt, 1);
      chk("stream_drained", exp_q.size(), 0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    i_rstn       = 1'b0;
    i_start      = 1'b0;
    i_src_valid  = 1'b0;
    i_src_data   = '0;
    i_pool_valid = 1'b0;
    repeat (3) @(negedge i_sclk);
    chk("rst_vsync", o_vsync, 0);
    chk("rst_hsync", o_hsync, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_tdata", o_tdata, 0);
    chk("rst_chan", o_chan, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
    chk("rst_ready", o_src_ready, 0);
    i_rstn = 1'b1;
    @(negedge i_sclk);
    chk("idle_busy", o_busy, 0);

    run_layer(1'b0, EXP_POOL,     EXP_POOL, 1'b0, 1'b0, 1'b0);  // nominal layer
    run_layer(1'b1, EXP_POOL,     EXP_POOL, 1'b1, 1'b1, 1'b0);  // source stall, starts while busy / at done
    run_layer(1'b0, EXP_POOL - 1, EXP_POOL, 1'b0, 1'b0, 1'b0);  // missing pooled output
    run_layer(1'b0, EXP_POOL + 1, EXP_POOL, 1'b0, 1'b0, 1'b0);  // extra pooled output
    run_layer(1'b0, EXP_POOL,     EXP_POOL, 1'b0, 1'b0, 1'b0);  // error cleared by this start
    run_layer(1'b1, EXP_POOL,     EXP_POOL, 1'b0, 1'b0, 1'b1);  // reset during ch 1 row 2
    run_layer(1'b0, EXP_POOL,     EXP_POOL, 1'b1, 1'b0, 1'b0);  // clean layer after abort

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
